cc_rdata_merge_unit: RTL and testbench

Parametrised read-data merge unit for the cache controller R path. It returns read bursts to the interconnect in request order by merging two sources. Miss lines stream from the memory-side AXI R channel. Hit lines come from an internal hit-data FIFO and are serialised with critical-word-first wrap ordering. A hit-flag FIFO, written in request order, selects the source for each burst.

---
 rtl/cc_rdata_merge_unit.sv | 161 ++++++++++++++++
 tb/tb_cc_rdata_merge_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_rdata_merge_unit.sv
// cc_rdata_merge_unit: in-order merge of memory R bursts and wrapped hit lines onto the interconnect R channel (macro CC_RDATA_MERGE_B2B_EN enables zero-bubble bursts)

// Registered FIFO with occupancy-based almost-full and a dropped-push indication
module cc_rdata_merge_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 2,
    parameter int AFULL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         afull_o,
    output logic         ovf_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    // Pointer and occupancy update; a same-cycle pop frees the slot a push into a full FIFO needs
    always_comb begin
        do_pop  = pop_i && cnt_q != '0;
        do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wp_q] = wdata_i;
        wp_d    = do_push ? (wp_q == AW'(DEPTH - 1) ? '0 : wp_q + AW'(1)) : wp_q;
        rp_d    = do_pop ? (rp_q == AW'(DEPTH - 1) ? '0 : rp_q + AW'(1)) : rp_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        rdata_o = mem_q[rp_q];
        empty_o = cnt_q == '0;
        afull_o = cnt_q >= CW'(AFULL);
        ovf_o   = push_i && !do_push;
    end
    // Occupancy state is flushed by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    // Entry storage needs no reset; validity comes from the occupancy count
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

module cc_rdata_merge_unit #(
    parameter int DATA_W      = 64,
    parameter int BEATS       = 8,
    parameter int OFS_W       = $clog2(DATA_W * BEATS / 8),
    parameter int FLAG_DEPTH  = 4,
    parameter int FLAG_AFULL  = 2,
    parameter int HDATA_DEPTH = 2,
    parameter int HDATA_AFULL = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_W-1:0]                 mem_rdata_i,
    input  logic                              mem_rlast_i,
    input  logic                              mem_rvalid_i,
    output logic                              mem_rready_o,
    output logic                              hit_flag_fifo_afull_o,
    input  logic                              hit_flag_fifo_wren_i,
    input  logic                              hit_flag_fifo_wdata_i,
    output logic                              hit_data_fifo_afull_o,
    input  logic                              hit_data_fifo_wren_i,
    input  logic [OFS_W+DATA_W*BEATS-1:0]     hit_data_fifo_wdata_i,
    output logic [DATA_W-1:0]                 inct_rdata_o,
    output logic                              inct_rlast_o,
    output logic                              inct_rvalid_o,
    input  logic                              inct_rready_i,
    output logic                              err_o
);
    localparam int LINE_W = DATA_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MISS = 2'd1;
    localparam logic [1:0] S_HIT  = 2'd2;
    logic [1:0]              state_q, state_d, flag_state;
    logic [CNT_W-1:0]        cnt_q, cnt_d, beat_idx;
    logic                    err_q, err_d;
    logic                    flag_rdata, flag_empty, flag_pop, flag_ovf;
    logic [OFS_W+LINE_W-1:0] hd_rdata;
    logic                    hd_empty, hd_pop, hd_ovf;
    logic                    in_miss, hit_vld, at_last, mem_hs, hit_hs, burst_end;
    logic                    ofs_unused;
    cc_rdata_merge_fifo #(.W(1), .DEPTH(FLAG_DEPTH), .AFULL(FLAG_AFULL)) u_flag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (hit_flag_fifo_wren_i),
        .wdata_i (hit_flag_fifo_wdata_i),
        .pop_i   (flag_pop),
        .rdata_o (flag_rdata),
        .empty_o (flag_empty),
        .afull_o (hit_flag_fifo_afull_o),
        .ovf_o   (flag_ovf)
    );
    cc_rdata_merge_fifo #(.W(OFS_W + LINE_W), .DEPTH(HDATA_DEPTH), .AFULL(HDATA_AFULL)) u_hdata_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (hit_data_fifo_wren_i),
        .wdata_i (hit_data_fifo_wdata_i),
        .pop_i   (hd_pop),
        .rdata_o (hd_rdata),
        .empty_o (hd_empty),
        .afull_o (hit_data_fifo_afull_o),
        .ovf_o   (hd_ovf)
    );
    // Sub-beat offset bits only select bytes within the first beat and do not affect ordering
    assign ofs_unused = ^hd_rdata[LINE_W +: (BYTE_W > 0 ? BYTE_W : 1)];
    // Handshakes and output muxing: MISS is a pure pass-through, HIT serves the line critical-word-first
    always_comb begin
        in_miss       = state_q == S_MISS;
        at_last       = cnt_q == CNT_W'(BEATS - 1);
        hit_vld       = state_q == S_HIT && !hd_empty;
        mem_hs        = in_miss && mem_rvalid_i && inct_rready_i;
        hit_hs        = hit_vld && inct_rready_i;
        burst_end     = (mem_hs && mem_rlast_i) || (hit_hs && at_last);
        hd_pop        = hit_hs && at_last;
        beat_idx      = hd_rdata[LINE_W + BYTE_W +: CNT_W] + cnt_q;
        mem_rready_o  = in_miss && inct_rready_i;
        inct_rvalid_o = in_miss ? mem_rvalid_i : hit_vld;
        inct_rlast_o  = in_miss ? mem_rlast_i : hit_vld && at_last;
        inct_rdata_o  = in_miss ? mem_rdata_i : hit_vld ? hd_rdata[beat_idx * DATA_W +: DATA_W] : '0;
    end
    // Burst sequencing: the next flag is taken in IDLE, or straight off a burst end when back-to-back is on
    always_comb begin
        flag_state = flag_rdata ? S_HIT : S_MISS;
`ifdef CC_RDATA_MERGE_B2B_EN
        flag_pop   = !flag_empty && (state_q == S_IDLE || burst_end);
`else
        flag_pop   = !flag_empty && state_q == S_IDLE;
`endif
        state_d    = flag_pop ? flag_state : burst_end ? S_IDLE : state_q;
        cnt_d      = burst_end ? '0 : (mem_hs || hit_hs) ? cnt_q + CNT_W'(1) : cnt_q;
        err_d      = err_q || flag_ovf || hd_ovf || (mem_hs && (mem_rlast_i != at_last));
    end
    // FSM state, beat counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign err_o = err_q;
endmodule

// File: tb/tb_cc_rdata_merge_unit.sv
// tb_cc_rdata_merge_unit: vector table, directed corner sequences and randomized bursts against an ordering model
module tb_cc_rdata_merge_unit;
    localparam int DATA_W = 64;
    localparam int BEATS  = 8;
    localparam int LINE_W = DATA_W * BEATS;
    localparam int OFS_W  = 6;
    localparam int HW     = OFS_W + LINE_W;
`ifdef CC_RDATA_MERGE_B2B_EN
    localparam int EXP_BUBBLES = 0;
`else
    localparam int EXP_BUBBLES = 1;
`endif
    typedef struct { logic [DATA_W-1:0] d; logic l; } beat_t;
    typedef struct { logic [OFS_W-1:0] ofs; logic [DATA_W-1:0] first; logic [DATA_W-1:0] last; } vec_t;

    logic              clk = 0;
    logic              rst_n = 0;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              mem_rlast_i = 0;
    logic              mem_rvalid_i = 0;
    logic              mem_rready_o;
    logic              hit_flag_fifo_afull_o;
    logic              hit_flag_fifo_wren_i = 0;
    logic              hit_flag_fifo_wdata_i = 0;
    logic              hit_data_fifo_afull_o;
    logic              hit_data_fifo_wren_i = 0;
    logic [HW-1:0]     hit_data_fifo_wdata_i = '0;
    logic [DATA_W-1:0] inct_rdata_o;
    logic              inct_rlast_o;
    logic              inct_rvalid_o;
    logic              inct_rready_i = 0;
    logic              err_o;

    int n_cmp = 0;
    int n_bad = 0;
    beat_t             mem_src[$];
    logic [DATA_W-1:0] exp_d[$];
    logic              exp_l[$];
    logic [DATA_W-1:0] got_d[$];
    logic              got_l[$];
    bit                vtrace[$];
    int                first_last_cyc;
    int                first_mem_cyc;
    vec_t              tv[6];

    cc_rdata_merge_unit dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mem_rdata_i           (mem_rdata_i),
        .mem_rlast_i           (mem_rlast_i),
        .mem_rvalid_i          (mem_rvalid_i),
        .mem_rready_o          (mem_rready_o),
        .hit_flag_fifo_afull_o (hit_flag_fifo_afull_o),
        .hit_flag_fifo_wren_i  (hit_flag_fifo_wren_i),
        .hit_flag_fifo_wdata_i (hit_flag_fifo_wdata_i),
        .hit_data_fifo_afull_o (hit_data_fifo_afull_o),
        .hit_data_fifo_wren_i  (hit_data_fifo_wren_i),
        .hit_data_fifo_wdata_i (hit_data_fifo_wdata_i),
        .inct_rdata_o          (inct_rdata_o),
        .inct_rlast_o          (inct_rlast_o),
        .inct_rvalid_o         (inct_rvalid_o),
        .inct_rready_i         (inct_rready_i),
        .err_o                 (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        mem_rvalid_i = 0;
        mem_rlast_i = 0;
        mem_rdata_i = '0;
        inct_rready_i = 0;
        hit_flag_fifo_wren_i = 0;
        hit_data_fifo_wren_i = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        mem_src.delete();
        exp_d.delete();
        exp_l.delete();
        got_d.delete();
        got_l.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_rready"}, 64'(mem_rready_o), 64'(0));
        chk({tag, "_rvalid"}, 64'(inct_rvalid_o), 64'(0));
        chk({tag, "_rlast"}, 64'(inct_rlast_o), 64'(0));
        chk({tag, "_rdata"}, inct_rdata_o, 64'(0));
        chk({tag, "_flag_afull"}, 64'(hit_flag_fifo_afull_o), 64'(0));
        chk({tag, "_data_afull"}, 64'(hit_data_fifo_afull_o), 64'(0));
        chk({tag, "_err"}, 64'(err_o), 64'(0));
    endtask

    task automatic push_flag(input logic f);
        @(negedge clk);
        hit_flag_fifo_wren_i = 1;
        hit_flag_fifo_wdata_i = f;
        @(posedge clk);
        #1;
        hit_flag_fifo_wren_i = 0;
    endtask

    task automatic push_line(input logic [HW-1:0] hd);
        @(negedge clk);
        hit_data_fifo_wren_i = 1;
        hit_data_fifo_wdata_i = hd;
        @(posedge clk);
        #1;
        hit_data_fifo_wren_i = 0;
    endtask

    function automatic logic [HW-1:0] mk_line(input logic [OFS_W-1:0] ofs, input logic [DATA_W-1:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*DATA_W +: DATA_W] = base + DATA_W'(k);
        return {ofs, l};
    endfunction

    function automatic logic [HW-1:0] rnd_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*DATA_W +: DATA_W] = {$urandom, $urandom};
        return {OFS_W'($urandom), l};
    endfunction

    // Model: a hit line is delivered starting at beat (byte offset / bytes-per-beat), wrapping modulo BEATS
    task automatic exp_hit(input logic [HW-1:0] hd);
        int s;
        s = int'(hd[LINE_W +: OFS_W]) / (DATA_W / 8);
        for (int i = 0; i < BEATS; i++) begin
            exp_d.push_back(hd[((s + i) % BEATS) * DATA_W +: DATA_W]);
            exp_l.push_back(i == BEATS - 1);
        end
    endtask

    // Model: a miss burst is delivered exactly as the memory presents it
    task automatic exp_miss(input logic [DATA_W-1:0] base, input int n, input int last_at, input bit rnd);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? {$urandom, $urandom} : base + DATA_W'(i);
            mem_src.push_back('{d, i == last_at});
            exp_d.push_back(d);
            exp_l.push_back(i == last_at);
        end
    endtask

    task automatic run(input int max_cyc, input int n_last, input bit rnd);
        int lasts;
        int cyc;
        bit pend;
        logic [DATA_W-1:0] pd;
        logic pl;
        lasts = 0;
        cyc = 0;
        pend = 0;
        pd = '0;
        pl = 0;
        first_last_cyc = -1;
        first_mem_cyc = -1;
        vtrace.delete();
        while (lasts < n_last && cyc < max_cyc) begin
            @(negedge clk);
            mem_rvalid_i = mem_src.size() > 0;
            mem_rdata_i = mem_rvalid_i ? mem_src[0].d : '0;
            mem_rlast_i = mem_rvalid_i ? mem_src[0].l : 1'b0;
            inct_rready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pend) begin
                chk("stall_valid", 64'(inct_rvalid_o), 64'(1));
                chk("stall_data", inct_rdata_o, pd);
                chk("stall_last", 64'(inct_rlast_o), 64'(pl));
            end
            pend = inct_rvalid_o && !inct_rready_i;
            pd = inct_rdata_o;
            pl = inct_rlast_o;
            vtrace.push_back(inct_rvalid_o);
            if (mem_rvalid_i && mem_rready_o) begin
                if (first_mem_cyc < 0) first_mem_cyc = cyc;
                void'(mem_src.pop_front());
            end
            if (inct_rvalid_o && inct_rready_i) begin
                got_d.push_back(inct_rdata_o);
                got_l.push_back(inct_rlast_o);
                if (inct_rlast_o) begin
                    lasts++;
                    if (first_last_cyc < 0) first_last_cyc = cyc;
                end
            end
            cyc++;
        end
        chk("burst_count", 64'(lasts), 64'(n_last));
        @(posedge clk);
        #1;
        mem_rvalid_i = 0;
        mem_rlast_i = 0;
        mem_rdata_i = '0;
        inct_rready_i = 0;
    endtask

    task automatic cmp_all(input string nm);
        chk($sformatf("%s_beats", nm), 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data[%0d]", nm, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_last[%0d]", nm, i), 64'(got_l[i]), 64'(exp_l[i]));
        end
        exp_d.delete();
        exp_l.delete();
        got_d.delete();
        got_l.delete();
        mem_src.delete();
    endtask

    initial begin
        logic [HW-1:0] hd;
        logic [1:0] fl;
        int nb;
        int first1;
        int ones;
        int zeros;
        tv[0] = '{6'h00, 64'hB0, 64'hB7};
        tv[1] = '{6'h28, 64'hB5, 64'hB4};
        tv[2] = '{6'h08, 64'hB1, 64'hB0};
        tv[3] = '{6'h3F, 64'hB7, 64'hB6};
        tv[4] = '{6'h17, 64'hB2, 64'hB1};
        tv[5] = '{6'h30, 64'hB6, 64'hB5};

        do_reset();
        #1;
        chk_reset_outputs("reset");

        hd = mk_line(6'h00, 64'hB0);
        push_line(hd);
        exp_miss(64'hA0, 8, 7, 0);
        exp_hit(hd);
        push_flag(0);
        push_flag(1);
        run(200, 2, 0);
        cmp_all("miss_then_hit");
        chk("err_clean", 64'(err_o), 64'(0));

        for (int v = 0; v < 6; v++) begin
            hd = mk_line(tv[v].ofs, 64'hB0);
            push_line(hd);
            if (v == 0) chk("data_afull_one_line", 64'(hit_data_fifo_afull_o), 64'(1));
            exp_hit(hd);
            push_flag(1);
            run(100, 1, 0);
            chk($sformatf("vec%0d_first", v), got_d.size() > 0 ? got_d[0] : 'x, tv[v].first);
            chk($sformatf("vec%0d_last", v), got_d.size() > 7 ? got_d[7] : 'x, tv[v].last);
            cmp_all($sformatf("vec%0d", v));
        end

        hd = mk_line(6'h10, 64'hD0);
        push_line(hd);
        exp_hit(hd);
        exp_miss(64'hC0, 8, 7, 0);
        push_flag(1);
        push_flag(0);
        run(200, 2, 0);
        chk("order_mem_after_hit", 64'(first_mem_cyc > first_last_cyc && first_last_cyc >= 0), 64'(1));
        cmp_all("order");

        hd = rnd_line();
        push_line(hd);
        exp_hit(hd);
        push_flag(1);
        run(400, 1, 1);
        cmp_all("stall_hit");

        hd = mk_line(6'h00, 64'hE0);
        push_line(hd);
        exp_hit(hd);
        hd = mk_line(6'h18, 64'hF0);
        push_line(hd);
        exp_hit(hd);
        push_flag(1);
        push_flag(1);
        run(200, 2, 0);
        first1 = -1;
        ones = 0;
        zeros = 0;
        foreach (vtrace[i]) begin
            if (vtrace[i]) begin
                if (first1 < 0) first1 = i;
                ones++;
            end else if (first1 >= 0 && ones < 2 * BEATS) zeros++;
        end
        chk("b2b_valid_cycles", 64'(ones), 64'(2 * BEATS));
        chk("b2b_bubbles", 64'(zeros), 64'(EXP_BUBBLES));
        cmp_all("b2b");

        for (int r = 0; r < 8; r++) begin
            nb = int'($urandom_range(1, 2));
            fl = 2'($urandom);
            for (int i = 0; i < nb; i++) begin
                if (fl[i]) begin
                    hd = rnd_line();
                    push_line(hd);
                    exp_hit(hd);
                end else exp_miss('0, 8, 7, 1);
            end
            for (int i = 0; i < nb; i++) push_flag(fl[i]);
            run(600, nb, 1);
            cmp_all($sformatf("rnd%0d", r));
        end
        chk("err_after_random", 64'(err_o), 64'(0));

        do_reset();
        exp_miss(64'h10, 5, 4, 0);
        push_flag(0);
        chk("early_last_err_before", 64'(err_o), 64'(0));
        run(100, 1, 0);
        chk("early_last_err", 64'(err_o), 64'(1));
        cmp_all("early_last");

        do_reset();
        exp_miss(64'h20, 9, 8, 0);
        push_flag(0);
        run(100, 1, 0);
        chk("late_last_err", 64'(err_o), 64'(1));
        cmp_all("late_last");

        do_reset();
        push_flag(0);
        @(negedge clk);
        for (int p = 1; p <= 5; p++) begin
            push_flag(0);
            chk($sformatf("flag_afull_%0d", p), 64'(hit_flag_fifo_afull_o), 64'(p >= 2));
            chk($sformatf("flag_err_%0d", p), 64'(err_o), 64'(p == 5));
        end
        @(negedge clk);
        mem_rvalid_i = 1;
        mem_rdata_i = 64'h55;
        inct_rready_i = 1;
        #1;
        chk("mid_burst_valid", 64'(inct_rvalid_o), 64'(1));
        chk("mid_burst_data", inct_rdata_o, 64'h55);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("flushed_rvalid", 64'(inct_rvalid_o), 64'(0));
        end
        mem_rvalid_i = 0;
        inct_rready_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
